exec_wb_unit: RTL and testbench

Multi-cycle execute/write-back sequencer that sits directly in front of reg_file (16 x 8-bit, combinational read ports, write on posedge clk when we=1).
- Accepts one decoded instruction through a valid/ready handshake.
- Reads source operands through reg_file's ra/rb ports and computes an 8-bit result (single-cycle ALU ops, or an iterative 8-step shift-add multiply).
- Writes the result back through wa/wd/we and updates Z/C flags.
- It is the only writer of reg_file.

---
 rtl/proto_pkg.sv | 34 +++
 rtl/alu8.sv | 62 ++++++
 rtl/reg_file.sv | 29 ++
 rtl/exec_wb_unit.sv | 178 +++++++++++++++++
 tb/tb_exec_wb_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proto_pkg.sv
// rtl/proto_pkg.sv - opcodes and sequencer state encodings shared by exec_wb_unit and alu8
package proto_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Codes above OP_MUL and OP_NOP itself retire without a register write.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

  // MOV and LDI leave the carry flag as it was.
  function automatic logic op_keeps_carry(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational ALU for all single-cycle ops
//   op     : opcode
//   a, b   : operands (b carries the immediate for LDI)
//   shamt  : shift amount for SHL/SHR
//   result : truncated result
//   carry  : carry / borrow / last bit shifted out (0 where not meaningful)
module alu8
  import proto_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   shamt,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] wide;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    wide   = '0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      OP_SUB: begin
        // Bit W of the extended difference is the unsigned borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        // The guard bit above the MSB catches the last bit pushed out.
        wide   = {1'b0, a} << shamt;
        result = wide[W-1:0];
        carry  = wide[W];
      end
      OP_SHR: begin
        // The guard bit below the LSB catches the last bit pushed out.
        wide   = {a, 1'b0} >> shamt;
        result = wide[W:1];
        carry  = wide[0];
      end
      OP_MOV: result = a;
      OP_LDI: result = b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16 x 8-bit register file, two combinational read ports, one write port
//   ra, rb / read_a, read_b : read addresses and data
//   wa, wd, we              : write address, data, enable (written on rising clk)
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign read_a = mem[ra];
  assign read_b = mem[rb];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/exec_wb_unit.sv
// rtl/exec_wb_unit.sv - multi-cycle execute/write-back sequencer in front of reg_file
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : instruction handshake (ready only in IDLE)
//   op, rd, rs1, rs2, imm  : decoded instruction fields, latched on accept
//   ra, rb / read_a, read_b: operand read port to reg_file
//   wa, wd, we             : write-back port to reg_file
//   flag_z, flag_c         : zero and carry flags, committed at write-back
//   done                   : one-cycle retire pulse
//   busy                   : sequencer not in IDLE
module exec_wb_unit
  import proto_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] ra,
  output logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] read_a,
  input  logic [DATA_W-1:0] read_b,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t              state_q, state_d;

  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [DATA_W-1:0]   result_q;
  logic                z_pend_q, c_pend_q;
  logic                flag_z_q, flag_c_q;

  logic [2*DATA_W-1:0] acc_q, mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                mul_last;

  // LDI routes its immediate through the ALU's b input.
  assign alu_b    = (op_q == OP_LDI) ? imm_q : opb_q;
  // After DATA_W shift-add steps one extra MUL cycle latches result and flags.
  assign mul_last = (cnt_q == CNT_W'(DATA_W));

  alu8 #(.W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (alu_b),
    .shamt  (imm_q[2:0]),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_READ;
      S_READ: state_d = (op_q == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = op_writes(op_q) ? S_WB : S_IDLE;
      S_MUL:  if (mul_last) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    if (!rst) begin
      in_ready = (state_q == S_IDLE);
      we       = (state_q == S_WB);
      done     = (state_q == S_WB) || ((state_q == S_EXEC) && !op_writes(op_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      z_pend_q <= 1'b0;
      c_pend_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
          end
        end
        S_READ: begin
          // Operands are frozen here, so rd==rs1/rs2 sees the pre-write value.
          opa_q    <= read_a;
          opb_q    <= read_b;
          acc_q    <= '0;
          mcand_q  <= {{DATA_W{1'b0}}, read_a};
          mplier_q <= read_b;
          cnt_q    <= '0;
        end
        S_EXEC: begin
          result_q <= alu_res;
          z_pend_q <= (alu_res == '0);
          c_pend_q <= op_keeps_carry(op_q) ? flag_c_q : alu_c;
        end
        S_MUL: begin
          if (mul_last) begin
            result_q <= acc_q[DATA_W-1:0];
            z_pend_q <= (acc_q[DATA_W-1:0] == '0);
            c_pend_q <= |acc_q[2*DATA_W-1:DATA_W];
          end else begin
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        S_WB: begin
          flag_z_q <= z_pend_q;
          flag_c_q <= c_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign ra     = rs1_q;
  assign rb     = rs2_q;
  assign wa     = rd_q;
  assign wd     = result_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_exec_wb_unit.sv
// tb/tb_exec_wb_unit.sv - self-checking bench for exec_wb_unit with a real reg_file
module tb_exec_wb_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [3:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic [3:0] ra, rb, wa;
  logic [7:0] read_a, read_b, wd;
  logic       we, flag_z, flag_c, done, busy;

  int errors = 0;
  int checks = 0;

  int mregs [16];
  int mz, mc;

  typedef struct {
    int o, d, s1, s2, im, wd, z, c;
  } vec_t;
  vec_t tab [16];

  always #5 clk = ~clk;

  exec_wb_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .ra(ra), .rb(rb), .read_a(read_a), .read_b(read_b),
    .wa(wa), .wd(wd), .we(we), .flag_z(flag_z), .flag_c(flag_c),
    .done(done), .busy(busy)
  );

  reg_file #(.DATA_W(8), .ADDR_W(4)) u_rf (
    .clk(clk), .ra(ra), .rb(rb), .read_a(read_a), .read_b(read_b),
    .wa(wa), .wd(wd), .we(we)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Architectural reference: what an instruction does to a register and the carry.
  function automatic void ref_exec(input int o, input int a, input int b, input int im,
                                   input int cin, output int res, output int c, output int w);
    int s;
    int full;
    s = im & 7;
    w = 1;
    c = 0;
    res = 0;
    case (o)
      1:  begin full = a + b; res = full % 256; c = (full > 255) ? 1 : 0; end
      2:  begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  begin res = (a * (1 << s)) % 256; c = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
      7:  begin res = a / (1 << s); c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
      8:  begin res = a; c = cin; end
      9:  begin res = im; c = cin; end
      10: begin full = a * b; res = full % 256; c = (full > 255) ? 1 : 0; end
      default: begin w = 0; c = cin; end
    endcase
  endfunction

  // Issue one instruction starting at a negedge and follow it until in_ready returns.
  task automatic run_instr(input int o, input int d, input int s1, input int s2, input int im,
                           input bit use_tab, input int t_wd, input int t_z, input int t_c);
    int ewd, ec, ew, ez, lat, n;
    int we_cnt, we_at, done_cnt, done_at, ready_bad, ready_back, got_wa, got_wd;
    ref_exec(o, mregs[s1], mregs[s2], im, mc, ewd, ec, ew);
    ez = (ew != 0) ? ((ewd == 0) ? 1 : 0) : mz;
    if (use_tab) begin
      ewd = t_wd;
      ez  = t_z;
      ec  = t_c;
    end
    lat = (ew == 0) ? 2 : ((o == 10) ? 11 : 3);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    op  = 4'(o);
    rd  = 4'(d);
    rs1 = 4'(s1);
    rs2 = 4'(s2);
    imm = 8'(im);
    @(negedge clk);
    in_valid = 1'b0;
    we_cnt = 0; we_at = 0; done_cnt = 0; done_at = 0;
    ready_bad = 0; ready_back = 0; got_wa = 0; got_wd = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (we) begin
        we_cnt++;
        we_at  = k;
        got_wa = int'(wa);
        got_wd = int'(wd);
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k <= lat) begin
        if (in_ready) ready_bad++;
        @(negedge clk);
      end else begin
        ready_back = int'(in_ready);
      end
    end
    chk($sformatf("op%0d_done_cycle", o), done_at, lat);
    chk($sformatf("op%0d_done_count", o), done_cnt, 1);
    chk($sformatf("op%0d_we_count", o), we_cnt, ew);
    if (ew != 0) begin
      chk($sformatf("op%0d_we_cycle", o), we_at, lat);
      chk($sformatf("op%0d_wa", o), got_wa, d);
      chk($sformatf("op%0d_wd", o), got_wd, ewd);
    end
    chk($sformatf("op%0d_ready_low", o), ready_bad, 0);
    chk($sformatf("op%0d_ready_back", o), ready_back, 1);
    chk($sformatf("op%0d_flag_z", o), int'(flag_z), ez);
    chk($sformatf("op%0d_flag_c", o), int'(flag_c), ec);
    if (ew != 0) mregs[d] = ewd;
    mz = ez;
    mc = ec;
  endtask

  task automatic burst();
    int bo [3];
    int bd [3];
    int bs1 [3];
    int bs2 [3];
    int bim [3];
    int exp_wd [3];
    int exp_wa [3];
    int got_wd [3];
    int got_wa [3];
    int res, c, w, idx, accepts, wcnt, pending;
    bo = '{1, 2, 9}; bd = '{12, 13, 14}; bs1 = '{1, 12, 0}; bs2 = '{2, 1, 0}; bim = '{0, 0, 'h33};
    for (int i = 0; i < 3; i++) begin
      ref_exec(bo[i], mregs[bs1[i]], mregs[bs2[i]], bim[i], mc, res, c, w);
      mregs[bd[i]] = res;
      mz = (res == 0) ? 1 : 0;
      mc = c;
      exp_wd[i] = res;
      exp_wa[i] = bd[i];
      got_wd[i] = -1;
      got_wa[i] = -1;
    end
    idx = 0; accepts = 0; wcnt = 0; pending = 0;
    in_valid = 1'b1;
    op = 4'(bo[0]); rd = 4'(bd[0]); rs1 = 4'(bs1[0]); rs2 = 4'(bs2[0]); imm = 8'(bim[0]);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (we) begin
        if (wcnt < 3) begin
          got_wa[wcnt] = int'(wa);
          got_wd[wcnt] = int'(wd);
        end
        wcnt++;
      end
      if (pending != 0) begin
        pending = 0;
        idx++;
        if (idx < 3) begin
          op = 4'(bo[idx]); rd = 4'(bd[idx]); rs1 = 4'(bs1[idx]);
          rs2 = 4'(bs2[idx]); imm = 8'(bim[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        pending = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("burst_accepts", accepts, 3);
    chk("burst_writes", wcnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("burst_wa%0d", i), got_wa[i], exp_wa[i]);
      chk($sformatf("burst_wd%0d", i), got_wd[i], exp_wd[i]);
    end
    chk("burst_flag_z", int'(flag_z), mz);
    chk("burst_flag_c", int'(flag_c), mc);
  endtask

  task automatic reset_mid_mul();
    int we_seen, n, old5;
    old5 = mregs[5];
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op = 4'd10; rd = 4'd5; rs1 = 4'd2; rs2 = 4'd2; imm = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    we_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      if (we) we_seen++;
      if (k < 5) @(negedge clk);
    end
    rst = 1'b1;
    if (we) we_seen++;
    @(negedge clk);
    if (we) we_seen++;
    chk("rstmid_we_seen", we_seen, 0);
    chk("rstmid_outs", int'({we, done, busy, flag_z, flag_c, wa, wd, ra, rb}), 0);
    chk("rstmid_ready_in_rst", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_after", int'(in_ready), 1);
    chk("rstmid_r5_kept", int'(u_rf.mem[5]), old5);
    mz = 0;
    mc = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    mz = 0; mc = 0;
    for (int i = 0; i < 16; i++) mregs[i] = 0;

    tab[0]  = '{9, 1, 0, 0, 'h0F, 'h0F, 0, 0};
    tab[1]  = '{9, 2, 0, 0, 'hF1, 'hF1, 0, 0};
    tab[2]  = '{1, 3, 1, 2, 0,    'h00, 1, 1};
    tab[3]  = '{2, 4, 1, 2, 0,    'h1E, 0, 1};
    tab[4]  = '{2, 7, 2, 1, 0,    'hE2, 0, 0};
    tab[5]  = '{10, 5, 1, 2, 0,   'h1F, 0, 1};
    tab[6]  = '{3, 9, 1, 2, 0,    'h01, 0, 0};
    tab[7]  = '{4, 10, 1, 2, 0,   'hFF, 0, 0};
    tab[8]  = '{5, 11, 1, 2, 0,   'hFE, 0, 0};
    tab[9]  = '{7, 6, 2, 0, 0,    'hF1, 0, 0};
    tab[10] = '{6, 6, 2, 0, 3,    'h88, 0, 1};
    tab[11] = '{9, 8, 0, 0, 'h5A, 'h5A, 0, 1};
    tab[12] = '{8, 8, 8, 0, 0,    'h5A, 0, 1};
    tab[13] = '{0, 15, 1, 2, 0,   0,    0, 1};
    tab[14] = '{13, 14, 1, 2, 0,  0,    0, 1};
    tab[15] = '{5, 12, 1, 1, 0,   'h00, 1, 0};

    repeat (3) @(negedge clk);
    chk("reset_outs", int'({we, done, busy, flag_z, flag_c, wa, wd, ra, rb}), 0);
    chk("reset_ready_in_rst", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_after", int'(in_ready), 1);

    // Give every register a known value so random reads are defined.
    for (int i = 0; i < 16; i++) begin
      run_instr(9, i, 0, 0, int'($urandom_range(1, 255)), 1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 16; i++) begin
      run_instr(tab[i].o, tab[i].d, tab[i].s1, tab[i].s2, tab[i].im,
                1'b1, tab[i].wd, tab[i].z, tab[i].c);
    end

    reset_mid_mul();
    burst();

    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)), 1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final_r%0d", i), int'(u_rf.mem[i]), mregs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
